snoop_dispatch: RTL and testbench

Steers packets captured by one AXI-Stream snooper to one of `N_CORES` packet-filter cores, so several filters share one snooped stream. At each packet start it picks the next ready, enabled core in round-robin order. It then locks to that core for the whole packet and forwards the `done` pulse only to that core. Packets that arrive when no core is eligible are discarded and counted. The block sits between the snooper's packet-memory write port and the cores' snooper-side write ports.

---
 rtl/snoop_dispatch.sv | 205 ++++++++++++++++++++
 tb/tb_snoop_dispatch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_dispatch.sv
// snoop_dispatch: steers packets from one AXI-Stream snooper to one of
// N_CORES packet-filter cores. The core is chosen round-robin at packet
// start and held for the whole packet. Packets with no eligible core are
// discarded and counted. All core-side outputs are registered (1-cycle latency).
module snoop_dispatch #(
    parameter int N_CORES        = 4,
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 64,
    parameter int DROP_CNT_WIDTH = 32
) (
    input  logic                         axi_aclk,
    input  logic                         axi_areset,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_en,
    input  logic                         done,
    output logic                         mem_ready,
    input  logic [N_CORES-1:0]           core_ready,
    input  logic [N_CORES-1:0]           core_en,
    output logic [ADDR_WIDTH-1:0]        core_wr_addr,
    output logic [DATA_WIDTH-1:0]        core_wr_data,
    output logic [N_CORES-1:0]           core_wr_en,
    output logic [N_CORES-1:0]           core_done,
    output logic [$clog2(N_CORES)-1:0]   sel,
    output logic                         busy,
    output logic [DROP_CNT_WIDTH-1:0]    drop_count
);

    localparam int SEL_W = $clog2(N_CORES);
    localparam logic [SEL_W-1:0]          LAST_RST = SEL_W'(N_CORES - 1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [N_CORES-1:0]        ONE_HOT0 = {{(N_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [SEL_W-1:0]          last_q, last_d;
    logic [N_CORES-1:0]        wr_en_q, wr_en_d;
    logic [N_CORES-1:0]        done_q, done_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic                      busy_q, busy_d;

    logic [N_CORES-1:0]        elig_s;
    logic [SEL_W-1:0]          cand_s;

    // Decode a core index into a one-hot strobe vector.
    function automatic logic [N_CORES-1:0] onehot(input logic [SEL_W-1:0] idx);
        return ONE_HOT0 << idx;
    endfunction

    // First eligible index searching upward from last+1, wrapping around.
    // Returns last unchanged when nothing is eligible (caller checks |elig).
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_CORES-1:0] elig,
                                                 input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] pos;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_CORES; i++) begin
            idx = (int'(last) + i) % N_CORES;
            pos = idx[SEL_W-1:0];
            if (!found && elig[pos]) begin
                pick  = pos;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Eligibility and round-robin candidate, only consumed at packet start.
    always_comb begin
        elig_s = core_ready & core_en;
        cand_s = rr_pick(elig_s, last_q);
    end

    // Next-state and registered-output decode for the dispatch FSM.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        wr_en_d = {N_CORES{1'b0}};
        done_d  = {N_CORES{1'b0}};
        addr_d  = addr_q;
        data_d  = data_q;
        drop_d  = drop_q;
        busy_d  = 1'b0;

        if (wr_en) begin
            addr_d = wr_addr;
            data_d = wr_data;
        end else begin
            addr_d = addr_q;
            data_d = data_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    if (|elig_s) begin
                        sel_d   = cand_s;
                        last_d  = cand_s;
                        wr_en_d = onehot(cand_s);
                        if (done) begin
                            // Single-beat packet: write and done together.
                            done_d  = onehot(cand_s);
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        if (drop_q != DROP_MAX) begin
                            drop_d = drop_q + DROP_ONE;
                        end else begin
                            drop_d = drop_q;
                        end
                        if (done) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                end else begin
                    // A done without any beat is a zero-length packet: ignore.
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (wr_en) begin
                    wr_en_d = onehot(sel_q);
                end else begin
                    wr_en_d = {N_CORES{1'b0}};
                end
                if (done) begin
                    done_d  = onehot(sel_q);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            ST_DROP: begin
                if (done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q <= ST_IDLE;
            sel_q   <= {SEL_W{1'b0}};
            last_q  <= LAST_RST;
            wr_en_q <= {N_CORES{1'b0}};
            done_q  <= {N_CORES{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            data_q  <= {DATA_WIDTH{1'b0}};
            drop_q  <= {DROP_CNT_WIDTH{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
        end
    end

    assign mem_ready    = 1'b1;
    assign core_wr_addr = addr_q;
    assign core_wr_data = data_q;
    assign core_wr_en   = wr_en_q;
    assign core_done    = done_q;
    assign sel          = sel_q;
    assign busy         = busy_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_snoop_dispatch.sv
// Directed bench for snoop_dispatch. A packet-level model (owner core,
// round-robin pointer, drop tally) predicts each cycle's outputs; every
// clock step compares the DUT against it, and literal checks pin key points.
module tb_snoop_dispatch;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          done;
    logic          mem_ready;
    logic [N-1:0]  core_ready;
    logic [N-1:0]  core_en;
    logic [AW-1:0] core_wr_addr;
    logic [DW-1:0] core_wr_data;
    logic [N-1:0]  core_wr_en;
    logic [N-1:0]  core_done;
    logic [1:0]    sel;
    logic          busy;
    logic [CW-1:0] drop_count;

    snoop_dispatch #(.N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(CW)) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
        .mem_ready(mem_ready), .core_ready(core_ready), .core_en(core_en),
        .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_wr_en(core_wr_en), .core_done(core_done),
        .sel(sel), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: owner = -1 idle, -2 dropping, else locked core index.
    int            m_owner;
    int            m_last;
    longint        m_drops;
    logic [N-1:0]  e_wr, e_done;
    int            e_sel;
    logic          e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    // Observed pulse tallies per core (from the DUT, compared to literals).
    int cnt_wr[N];
    int cnt_done[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_drops = 0;
        e_wr    = '0;
        e_done  = '0;
        e_sel   = 0;
        e_busy  = 1'b0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    task automatic model_step();
        logic [N-1:0] elig;
        int pick, c;
        e_wr   = '0;
        e_done = '0;
        if (wr_en) begin
            e_addr = wr_addr;
            e_data = wr_data;
        end
        if (m_owner == -1) begin
            if (wr_en) begin
                elig = core_ready & core_en;
                if (elig != '0) begin
                    pick = -1;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (pick < 0 && elig[c]) pick = c;
                    end
                    m_last = pick;
                    e_sel  = pick;
                    e_wr   = 4'b0001 << pick;
                    if (done) e_done = 4'b0001 << pick;
                    else      m_owner = pick;
                end else begin
                    if (m_drops < 64'hFFFF_FFFF) m_drops++;
                    if (!done) m_owner = -2;
                end
            end
        end else if (m_owner >= 0) begin
            if (wr_en) e_wr = 4'b0001 << m_owner;
            if (done) begin
                e_done  = 4'b0001 << m_owner;
                m_owner = -1;
            end
        end else begin
            if (done) m_owner = -1;
        end
        e_busy = (m_owner != -1);
    endtask

    task automatic compare();
        chk("core_wr_en", 64'(core_wr_en), 64'(e_wr));
        chk("core_done",  64'(core_done),  64'(e_done));
        chk("sel",        64'(sel),        64'(e_sel));
        chk("busy",       64'(busy),       64'(e_busy));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        chk("mem_ready",  64'(mem_ready),  64'd1);
        if (e_wr != '0) begin
            chk("core_wr_addr", 64'(core_wr_addr), 64'(e_addr));
            chk("core_wr_data", core_wr_data, e_data);
        end
        for (int i = 0; i < N; i++) begin
            if (core_wr_en[i]) cnt_wr[i]++;
            if (core_done[i])  cnt_done[i]++;
        end
    endtask

    // One clock: predict, advance past the edge, compare.
    task automatic step();
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic beat(input logic we, input logic dn, input int a);
        wr_en   = we;
        done    = dn;
        wr_addr = AW'(a);
        wr_data = 64'hDEAD_BEEF_0000_0000 | 64'(a * 3 + 1);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 0);
    endtask

    // n beats; done either on the last beat or on a separate following cycle.
    task automatic pkt(input int n, input logic done_last);
        for (int i = 0; i < n; i++) beat(1'b1, done_last && (i == n - 1), i);
        if (!done_last) beat(1'b0, 1'b1, 0);
    endtask

    int w0[N];
    int d0[N];

    task automatic snap();
        for (int i = 0; i < N; i++) begin
            w0[i] = cnt_wr[i];
            d0[i] = cnt_done[i];
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            cnt_wr[i]   = 0;
            cnt_done[i] = 0;
        end
        rst        = 1'b1;
        wr_en      = 1'b0;
        done       = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        core_ready = 4'b1111;
        core_en    = 4'b1111;
        model_reset();
        step();
        step();
        rst = 1'b0;
        idle(2);
        // Reset state literals.
        chk("rst_sel",  64'(sel), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_wr",   64'(core_wr_en), 64'd0);

        // Three 8-beat packets, all eligible -> cores 0,1,2.
        snap();
        beat(1'b1, 1'b0, 0);
        chk("t1_first_wr",   64'(core_wr_en), 64'h1);
        chk("t1_first_addr", 64'(core_wr_addr), 64'd0);
        for (int i = 1; i < 8; i++) beat(1'b1, 1'b0, i);
        beat(1'b0, 1'b1, 0);
        chk("t1_done0", 64'(core_done), 64'h1);
        idle(1);
        pkt(8, 1'b0);
        idle(1);
        pkt(8, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_wrcnt%0d", i), 64'(cnt_wr[i] - w0[i]), 64'd8);
            chk($sformatf("t1_donecnt%0d", i), 64'(cnt_done[i] - d0[i]), 64'd1);
        end
        chk("t1_wrcnt3", 64'(cnt_wr[3] - w0[3]), 64'd0);
        chk("t1_sel", 64'(sel), 64'd2);

        // Enable mask 1010 -> core 3, then wrap to core 1.
        core_en = 4'b1010;
        snap();
        pkt(2, 1'b0);
        chk("t2_sel_a", 64'(sel), 64'd3);
        idle(1);
        pkt(2, 1'b0);
        chk("t2_sel_b", 64'(sel), 64'd1);
        idle(1);
        chk("t2_done3", 64'(cnt_done[3] - d0[3]), 64'd1);
        chk("t2_done1", 64'(cnt_done[1] - d0[1]), 64'd1);

        // No core ready: 5-beat packet dropped.
        core_en    = 4'b1111;
        core_ready = 4'b0000;
        snap();
        beat(1'b1, 1'b0, 0);
        chk("t3_busy_hi", 64'(busy), 64'd1);
        for (int i = 1; i < 5; i++) beat(1'b1, 1'b0, i);
        beat(1'b0, 1'b1, 0);
        chk("t3_busy_lo", 64'(busy), 64'd0);
        chk("t3_drop", 64'(drop_count), 64'd1);
        chk("t3_nowr", 64'((cnt_wr[0]-w0[0]) + (cnt_wr[1]-w0[1]) + (cnt_wr[2]-w0[2]) + (cnt_wr[3]-w0[3])), 64'd0);
        idle(1);

        // Single-beat packet, only core 2 eligible; next search from core 3.
        core_ready = 4'b0100;
        beat(1'b1, 1'b1, 5);
        chk("t4_wr",   64'(core_wr_en), 64'h4);
        chk("t4_done", 64'(core_done), 64'h4);
        chk("t4_busy", 64'(busy), 64'd0);
        core_ready = 4'b1111;
        beat(1'b1, 1'b0, 0);
        chk("t4_next", 64'(sel), 64'd3);
        beat(1'b0, 1'b1, 0);
        idle(1);

        // Core 0 locked; ready[0] drops at beat 3; back-to-back next packet.
        snap();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) core_ready = 4'b1110;
            beat(1'b1, i == 5, i);
        end
        chk("t5_done0", 64'(core_done), 64'h1);
        beat(1'b1, 1'b0, 0);
        chk("t5_b2b_wr", 64'(core_wr_en), 64'h2);
        chk("t5_wrcnt0", 64'(cnt_wr[0] - w0[0]), 64'd6);
        beat(1'b1, 1'b0, 1);
        beat(1'b0, 1'b1, 0);
        core_ready = 4'b1111;
        idle(1);

        // Reset at beat 4 of a packet (to core 2); restart goes to core 0.
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, i);
        chk("t6_pre_sel", 64'(sel), 64'd2);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_async_wr",   64'(core_wr_en), 64'd0);
        chk("t6_async_busy", 64'(busy), 64'd0);
        chk("t6_async_drop", 64'(drop_count), 64'd0);
        chk("t6_async_sel",  64'(sel), 64'd0);
        beat(1'b1, 1'b0, 4);
        beat(1'b1, 1'b0, 5);
        rst = 1'b0;
        beat(1'b1, 1'b0, 6);
        chk("t6_restart_sel", 64'(sel), 64'd0);
        chk("t6_restart_wr",  64'(core_wr_en), 64'h1);
        beat(1'b1, 1'b1, 7);
        chk("t6_restart_done", 64'(core_done), 64'h1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
